uart_rx_framer: RTL

//  Standalone UART receive front-end: the serial-in end of the link driven by our Transmitter.

---
 rtl/uart_rx_framer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises rx, samples data bits at mid-bit on the 16x s_tick
// and reports each byte with framing/break status. Define UART_RX_PARITY_EN to add a parity bit.
module uart_rx_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int TIME       = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  s_tick,
    output logic [DATA_WIDTH-1:0] rx_out,
    output logic                  rx_done_tick,
    output logic                  frame_err,
    output logic                  break_det,
    output logic                  parity_err
);

    localparam int CW = $clog2(TIME);
    localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NW-1:0]         nbit_q, nbit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] rx_out_q, rx_out_d;
    logic                  done_q, done_d;
    logic                  frame_err_q, frame_err_d;
    logic                  break_q, break_d;
    logic                  fall_edge;
    logic                  cnt_half, cnt_full;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_q, par_bit_d;
    logic                  par_err_q, par_err_d;
`endif

    // Two-flop synchroniser plus one delayed copy for edge detection; idle level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall_edge = rx_prev_q & ~rx_s_q;
    assign cnt_half  = (cnt_q == CW'(TIME / 2 - 1));
    assign cnt_full  = (cnt_q == CW'(TIME - 1));

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbit_d      = nbit_q;
        shreg_d     = shreg_q;
        rx_out_d    = rx_out_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
        break_d     = break_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (fall_edge) begin
                    state_d     = S_START;
                    cnt_d       = '0;
                    frame_err_d = 1'b0;
                    break_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_err_d   = 1'b0;
`endif
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (cnt_half) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                        cnt_d   = '0;
                        nbit_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (cnt_full) begin
                        cnt_d   = '0;
                        shreg_d = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
                        if (nbit_q == NW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            nbit_d = nbit_q + NW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (s_tick) begin
                    if (cnt_full) begin
                        cnt_d     = '0;
                        par_bit_d = rx_s_q;
                        state_d   = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (s_tick) begin
                    if (cnt_full) begin
                        // Leave at mid-stop so the next start edge always finds us in IDLE.
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        rx_out_d    = shreg_q;
                        done_d      = 1'b1;
                        frame_err_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        break_d     = ~rx_s_q & (shreg_q == '0) & ~par_bit_q;
                        par_err_d   = ((^shreg_q) ^ par_bit_q) != PARITY_ODD;
`else
                        break_d     = ~rx_s_q & (shreg_q == '0);
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            nbit_q      <= '0;
            shreg_q     <= '0;
            rx_out_q    <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbit_q      <= nbit_d;
            shreg_q     <= shreg_d;
            rx_out_q    <= rx_out_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rx_out       = rx_out_q;
    assign rx_done_tick = done_q;
    assign frame_err    = frame_err_q;
    assign break_det    = break_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = par_err_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule
